// File: rtl/mem_if_arb_pkg.sv
// Shared types for the multi-client SRAM interface arbiter.
// Holds request opcodes, FSM states and the index-width helper.
package mem_if_arb_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_LOAD    = 2'd1,
        OP_STORE   = 2'd2,
        OP_ILLEGAL = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mif_state_e;

    // A one-channel build still needs a 1-bit index signal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_if_arb_rr_arbiter.sv
// Round-robin picker: lowest requesting index >= ptr, else lowest overall.
// Purely combinational, zero latency; no backpressure (grant follows req).
module rr_arbiter
    import mem_if_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic          w_hi_vld;
    logic          w_lo_vld;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;

    // Descending scan so the last hit is the lowest index in each half.
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IW'(j);
                if (j >= int'(i_ptr)) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IW'(j);
                end
            end
        end
    end

    assign o_vld   = w_lo_vld;
    assign o_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign o_grant = w_lo_vld ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/mem_if_arb.sv
// Multi-channel load/store front end sharing one single-port SRAM, round-robin served.
// Pulse-to-done latency 3 + strobe cycles; pulses on a busy channel are dropped.
module mem_if_arb
    import mem_if_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 14,
    parameter int WDATA_W = 16,
    parameter int RDATA_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_store,
    input  logic [NUM_CH-1:0]         ch_load,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH*WDATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [NUM_CH-1:0]         ch_error,
    output logic [RDATA_W-1:0]        ch_rdata,
    output logic                      read_req,
    output logic                      write_req,
    output logic [ADDR_W-1:0]         addrout,
    output logic [WDATA_W-1:0]        datatomem,
    input  logic [RDATA_W-1:0]        datafrommem,
    input  logic                      mem_resp
);

    localparam int IW = idx_w(NUM_CH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        mem_op_e              op;
        logic [ADDR_W-1:0]    addr;
        logic [WDATA_W-1:0]   wdata;
    } chan_req_t;

    chan_req_t          r_pend [NUM_CH];
    mif_state_e         r_state;
    mif_state_e         w_state_nxt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gnt;
    logic [NUM_CH-1:0]  r_gnt_oh;
    logic [CW-1:0]      r_cnt;
    logic               r_rd;
    logic               r_wr;
    logic               r_err;
    logic [RDATA_W-1:0] r_rdata;

    logic [NUM_CH-1:0]  w_pend_vld;
    logic [NUM_CH-1:0]  w_grant;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_gnt_vld;
    chan_req_t          w_cur;
    logic               w_timeout;
    logic               w_wait_end;

    always_comb begin
        w_pend_vld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pend_vld[i] = (r_pend[i].op != OP_NONE);
        end
    end

    assign w_cur      = r_pend[r_gnt];
    assign w_timeout  = (r_cnt == CW'(TIMEOUT));
    assign w_wait_end = mem_resp || w_timeout;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req   (w_pend_vld),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_vld   (w_gnt_vld)
    );

    // Completion clear wins over capture; a busy channel cannot capture anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_state == DONE && r_gnt_oh[i]) begin
                    r_pend[i].op <= OP_NONE;
                end else if (!w_pend_vld[i] && (ch_store[i] || ch_load[i])) begin
                    r_pend[i].op    <= (ch_store[i] && ch_load[i]) ? OP_ILLEGAL :
                                       ch_store[i]                 ? OP_STORE   : OP_LOAD;
                    r_pend[i].addr  <= ch_addr[i*ADDR_W +: ADDR_W];
                    r_pend[i].wdata <= ch_wdata[i*WDATA_W +: WDATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = (w_cur.op == OP_ILLEGAL) ? DONE : WAIT;
            WAIT:    if (w_wait_end) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A response arriving on the timeout cycle still counts as success.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_gnt_oh <= '0;
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err <= 1'b0;
                    if (w_gnt_vld) begin
                        r_gnt    <= w_gnt_idx;
                        r_gnt_oh <= w_grant;
                        r_ptr    <= (int'(w_gnt_idx) == NUM_CH - 1) ? '0 : w_gnt_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    r_cnt <= CW'(1);
                    r_wr  <= (w_cur.op == OP_STORE);
                    r_rd  <= (w_cur.op == OP_LOAD);
                    r_err <= (w_cur.op == OP_ILLEGAL);
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_wait_end) begin
                        r_rd  <= 1'b0;
                        r_wr  <= 1'b0;
                        r_err <= !mem_resp;
                        if (mem_resp && r_rd) begin
                            r_rdata <= datafrommem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_done   = '0;
        ch_error  = '0;
        addrout   = '0;
        datatomem = '0;
        if (r_state == ISSUE || r_state == WAIT) begin
            addrout   = w_cur.addr;
            datatomem = w_cur.wdata;
        end
        if (r_state == DONE) begin
            ch_done  = r_gnt_oh;
            ch_error = r_err ? r_gnt_oh : '0;
        end
    end

    assign ch_busy   = w_pend_vld;
    assign ch_rdata  = r_rdata;
    assign read_req  = r_rd;
    assign write_req = r_wr;

endmodule
